// File: rtl/hnf_link_rx_chan_pkg.sv
// Shared constants and helpers for the HN-F CHI-E link-layer RX channel.
package hnf_link_rx_chan_pkg;

   localparam int CHIE_DAT_FLIT_WIDTH        = 392;
   localparam int CHIE_DAT_FLIT_OPCODE_LSB   = 26;
   localparam int CHIE_DAT_FLIT_OPCODE_WIDTH = 4;
   localparam int HNF_LCRD_MAX               = 15;

   typedef enum logic [1:0] {
      CHAN_REQ,
      CHAN_RSP,
      CHAN_SNP,
      CHAN_DAT
   } hnf_chan_e;

   // LCrdReturn uses opcode 0 on every CHI-E channel
   localparam int LCRDRET_OPC_REQ = 0;
   localparam int LCRDRET_OPC_RSP = 0;
   localparam int LCRDRET_OPC_SNP = 0;
   localparam int LCRDRET_OPC_DAT = 0;

   // Width of a counter that must hold the values 0..depth inclusive
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/hnf_link_rx_chan_if.sv
// Link-side and consumer-side signals of one HN-F RX channel.
interface hnf_link_rx_chan_if
   import hnf_link_rx_chan_pkg::*;
#(
   parameter int FLIT_W = CHIE_DAT_FLIT_WIDTH,
   parameter int DEPTH  = HNF_LCRD_MAX
);
   localparam int CNT_W = cnt_width(DEPTH);

   logic              rxflitpend;
   logic              rxflitv;
   logic [FLIT_W-1:0] rxflit;
   logic              rxlcrdv;
   logic              link_active;
   logic              crd_idle;
   logic              out_valid;
   logic [FLIT_W-1:0] out_flit;
   logic              out_ready;
   logic [CNT_W-1:0]  fifo_cnt;
   logic              wake_q;
   logic              err_nocrd;
   logic              err_ovf;

   // Link pins, link control and consumer ready side
   modport master (
      output rxflitpend, rxflitv, rxflit, link_active, out_ready,
      input  rxlcrdv, crd_idle, out_valid, out_flit, fifo_cnt, wake_q, err_nocrd, err_ovf
   );

   // The RX channel itself
   modport slave (
      input  rxflitpend, rxflitv, rxflit, link_active, out_ready,
      output rxlcrdv, crd_idle, out_valid, out_flit, fifo_cnt, wake_q, err_nocrd, err_ovf
   );

endinterface

// File: rtl/hnf_sync_fifo.sv
// Registered FIFO with modulo-DEPTH pointer wrap (DEPTH need not be a power of 2).
// A read frees its slot in the same cycle, so a write into a full FIFO is accepted
// when a read happens alongside it.
module hnf_sync_fifo
   import hnf_link_rx_chan_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = cnt_width(DEPTH)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_rd;
   logic             do_wr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_rd   = rd_en & ~empty;
   assign do_wr   = wr_en & (~full | do_rd);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // Storage is not reset; the empty flag masks stale contents on rd_data
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
         if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/hnf_link_rx_chan.sv
// CHI-E link-layer RX channel for HN-F: grants L-credits only against free buffer
// slots, buffers received flits, absorbs LCrdReturn flits during deactivation and
// flags link protocol errors.
module hnf_link_rx_chan
   import hnf_link_rx_chan_pkg::*;
#(
   parameter int FLIT_W      = CHIE_DAT_FLIT_WIDTH,
   parameter int DEPTH       = HNF_LCRD_MAX,
   parameter int OPC_LSB     = CHIE_DAT_FLIT_OPCODE_LSB,
   parameter int OPC_W       = CHIE_DAT_FLIT_OPCODE_WIDTH,
   parameter int LCRDRET_OPC = 0
)(
   input logic               clk,
   input logic               rst,
   hnf_link_rx_chan_if.slave ch
);
   localparam int CNT_W = cnt_width(DEPTH);

   logic [CNT_W-1:0]  crd_out;
   logic [CNT_W-1:0]  fifo_cnt;
   logic [CNT_W:0]    avail;
   logic              issue;
   logic              has_crd;
   logic              is_lcrdret;
   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FLIT_W-1:0] head_flit;
   logic              rxlcrdv_q;
   logic              wake_q;
   logic              err_nocrd;
   logic              err_ovf;

   // avail carries a sign bit so a protocol-error overshoot can never look like free space
   assign avail      = (CNT_W+1)'(DEPTH) - {1'b0, fifo_cnt} - {1'b0, crd_out};
   assign issue      = ch.link_active & (avail != '0) & ~avail[CNT_W];
   assign has_crd    = (crd_out != '0);
   assign is_lcrdret = (ch.rxflit[OPC_LSB +: OPC_W] == OPC_W'(LCRDRET_OPC));
   assign push       = ch.rxflitv & ~is_lcrdret;
   assign pop        = ~fifo_empty & ch.out_ready;

   hnf_sync_fifo #(
      .WIDTH (FLIT_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (ch.rxflit),
      .rd_en   (ch.out_ready),
      .rd_data (head_flit),
      .count   (fifo_cnt),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Outstanding credits: +1 on each grant, -1 on each received flit, never below zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crd_out <= '0;
      end else begin
         case ({issue, ch.rxflitv & has_crd})
            2'b10:   crd_out <= crd_out + 1'b1;
            2'b01:   crd_out <= crd_out - 1'b1;
            default: ;
         endcase
      end
   end

   // Registered credit grant, wake hint and sticky error flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxlcrdv_q <= 1'b0;
         wake_q    <= 1'b0;
         err_nocrd <= 1'b0;
         err_ovf   <= 1'b0;
      end else begin
         rxlcrdv_q <= issue;
         wake_q    <= ch.rxflitpend;
         if (ch.rxflitv & ~has_crd)       err_nocrd <= 1'b1;
         if (push & fifo_full & ~pop)     err_ovf   <= 1'b1;
      end
   end

   assign ch.rxlcrdv   = rxlcrdv_q;
   assign ch.crd_idle  = ~has_crd & ~rxlcrdv_q;
   assign ch.out_valid = ~fifo_empty;
   assign ch.out_flit  = head_flit;
   assign ch.fifo_cnt  = fifo_cnt;
   assign ch.wake_q    = wake_q;
   assign ch.err_nocrd = err_nocrd;
   assign ch.err_ovf   = err_ovf;

endmodule

// File: tb/tb_hnf_link_rx_chan.sv
// Directed bench for hnf_link_rx_chan: a DEPTH=15 and a DEPTH=4 instance, 16-bit
// flits with the opcode in bits [15:12] and LCrdReturn = opcode 0.
module tb_hnf_link_rx_chan;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   hnf_link_rx_chan_if #(.FLIT_W(16), .DEPTH(15)) if15 ();
   hnf_link_rx_chan_if #(.FLIT_W(16), .DEPTH(4))  if4 ();

   hnf_link_rx_chan #(.FLIT_W(16), .DEPTH(15), .OPC_LSB(12), .OPC_W(4), .LCRDRET_OPC(0)) d15 (
      .clk (clk),
      .rst (rst),
      .ch  (if15)
   );

   hnf_link_rx_chan #(.FLIT_W(16), .DEPTH(4), .OPC_LSB(12), .OPC_W(4), .LCRDRET_OPC(0)) d4 (
      .clk (clk),
      .rst (rst),
      .ch  (if4)
   );

   typedef struct {
      logic        la;
      logic        fv;
      logic        rdy;
      logic        pend;
      logic [15:0] flit;
      logic        exp_lcrdv;
      logic        exp_valid;
      logic [15:0] exp_flit;
      logic [2:0]  exp_cnt;
      logic        exp_idle;
      logic        exp_wake;
      logic        exp_nocrd;
      logic        exp_ovf;
   } vec_t;

   vec_t        tbl [8];
   logic [15:0] exp_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [63:0] pack15();
      return {38'd0, if15.rxlcrdv, if15.out_valid, if15.out_flit, if15.fifo_cnt,
              if15.crd_idle, if15.wake_q, if15.err_nocrd, if15.err_ovf};
   endfunction

   function automatic logic [63:0] pack4();
      return {39'd0, if4.rxlcrdv, if4.out_valid, if4.out_flit, if4.fifo_cnt,
              if4.crd_idle, if4.wake_q, if4.err_nocrd, if4.err_ovf};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      if4.link_active = v.la;
      if4.rxflitv     = v.fv;
      if4.out_ready   = v.rdy;
      if4.rxflitpend  = v.pend;
      if4.rxflit      = v.flit;
   endtask

   task automatic idleInputs();
      if15.rxflitpend = 1'b0; if15.rxflitv = 1'b0; if15.rxflit = '0; if15.out_ready = 1'b0;
      if4.rxflitpend  = 1'b0; if4.rxflitv  = 1'b0; if4.rxflit  = '0; if4.out_ready  = 1'b0;
   endtask

   task automatic applyReset(input logic la);
      rst = 1'b1;
      idleInputs();
      if15.link_active = la;
      if4.link_active  = la;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [19:0] grant_bits;
      logic [2:0]  pop_bits;
      logic        any_valid;
      int          tx_cred;
      int          sent;
      int          received;
      int          cycles;
      logic [15:0] exp_d;

      checks = 0;
      errors = 0;
      rst    = 1'b1;
      idleInputs();
      if15.link_active = 1'b1;
      if4.link_active  = 1'b1;
      step();

      // Reset state, even with link_active high
      checkOutput("reset outputs d15", pack15(), {38'd0, 1'b0, 1'b0, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
      checkOutput("reset outputs d4",  pack4(),  {39'd0, 1'b0, 1'b0, 16'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
      checkOutput("reset crd_out d15", d15.crd_out, 0);

      // Table-driven sequence on the DEPTH=4 instance
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h1111, 1'b1, 1'b1, 16'h1111, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h2222, 1'b1, 1'b1, 16'h2222, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h3333, 1'b1, 1'b1, 16'h3333, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0abc, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h4444, 1'b0, 1'b1, 16'h4444, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h4444, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0};

      applyReset(1'b0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(tbl[i]);
         step();
         checkOutput($sformatf("table row %0d", i), pack4(),
                     {39'd0, tbl[i].exp_lcrdv, tbl[i].exp_valid, tbl[i].exp_flit, tbl[i].exp_cnt,
                      tbl[i].exp_idle, tbl[i].exp_wake, tbl[i].exp_nocrd, tbl[i].exp_ovf});
      end
      idleInputs();

      // Credit ramp after reset: 15 back-to-back grants then silence
      $display("[TB] credit ramp on DEPTH=15");
      applyReset(1'b1);
      for (int i = 0; i < 20; i++) begin
         step();
         grant_bits[i] = if15.rxlcrdv;
      end
      checkOutput("ramp grant pattern", grant_bits, 20'h07FFF);
      checkOutput("ramp crd_out", d15.crd_out, 15);
      checkOutput("ramp crd_idle", if15.crd_idle, 0);

      // Fill all 15 slots without popping, then one pop yields one grant two cycles later
      for (int i = 0; i < 15; i++) begin
         if15.rxflitv = 1'b1;
         if15.rxflit  = 16'h1000 | 16'(i);
         step();
      end
      if15.rxflitv = 1'b0;
      checkOutput("full fifo_cnt", if15.fifo_cnt, 15);
      checkOutput("full crd_out", d15.crd_out, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         pop_bits[i] = if15.rxlcrdv;
      end
      checkOutput("full no grants", pop_bits, 3'b000);
      checkOutput("full head flit", if15.out_flit, 16'h1000);
      if15.out_ready = 1'b1;
      step();
      pop_bits[0] = if15.rxlcrdv;
      if15.out_ready = 1'b0;
      step();
      pop_bits[1] = if15.rxlcrdv;
      step();
      pop_bits[2] = if15.rxlcrdv;
      checkOutput("pop regrant timing", pop_bits, 3'b010);
      checkOutput("pop next head", if15.out_flit, 16'h1001);
      checkOutput("pop fifo_cnt", if15.fifo_cnt, 14);

      // Deactivation with 6 credits out, drained by LCrdReturn flits
      $display("[TB] drain sequence");
      applyReset(1'b1);
      repeat (6) step();
      if15.link_active = 1'b0;
      step();
      checkOutput("drain start crd_out", d15.crd_out, 6);
      checkOutput("drain start grant/idle", {if15.rxlcrdv, if15.crd_idle}, 2'b00);
      any_valid = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         if15.rxflitv = 1'b1;
         if15.rxflit  = 16'(i);
         step();
         any_valid = any_valid | if15.out_valid;
         if (i == 5) checkOutput("drain idle after 5", if15.crd_idle, 0);
      end
      if15.rxflitv = 1'b0;
      checkOutput("drain idle after 6", if15.crd_idle, 1);
      checkOutput("drain nothing buffered", {any_valid, if15.fifo_cnt}, 0);
      if15.link_active = 1'b1;
      step();
      checkOutput("drain regrant", if15.rxlcrdv, 1);

      // Error flags: no-credit receive, legal push+pop at full, overflow drop
      $display("[TB] error flags");
      applyReset(1'b0);
      for (int i = 0; i < 15; i++) begin
         if15.rxflitv = 1'b1;
         if15.rxflit  = 16'h5000 | 16'(i);
         step();
         if (i == 0) checkOutput("nocrd after first", if15.err_nocrd, 1);
      end
      if15.rxflitv = 1'b0;
      checkOutput("nocrd fill cnt/ovf", {if15.fifo_cnt, if15.err_ovf}, {4'd15, 1'b0});
      repeat (2) step();
      checkOutput("nocrd sticky", if15.err_nocrd, 1);
      if15.rxflitv   = 1'b1;
      if15.rxflit    = 16'h6666;
      if15.out_ready = 1'b1;
      step();
      checkOutput("full push+pop", {if15.fifo_cnt, if15.err_ovf}, {4'd15, 1'b0});
      if15.out_ready = 1'b0;
      if15.rxflit    = 16'h7EEE;
      step();
      if15.rxflitv = 1'b0;
      checkOutput("overflow flag", {if15.fifo_cnt, if15.err_ovf}, {4'd15, 1'b1});
      if15.out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         exp_d = (i < 14) ? (16'h5001 + 16'(i)) : 16'h6666;
         checkOutput($sformatf("overflow drain %0d", i), {if15.out_valid, if15.out_flit}, {1'b1, exp_d});
         step();
      end
      if15.out_ready = 1'b0;
      checkOutput("overflow dropped", {if15.out_valid, if15.err_ovf}, 2'b01);

      // Reset in the middle of operation: 3 flits buffered, 5 credits out
      $display("[TB] mid-operation reset");
      applyReset(1'b1);
      repeat (8) step();
      if15.link_active = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if15.rxflitv = 1'b1;
         if15.rxflit  = 16'h8000 | 16'(i);
         step();
      end
      if15.rxflitv = 1'b0;
      checkOutput("pre-reset cnt/crd", {if15.fifo_cnt, d15.crd_out}, {4'd3, 4'd5});
      rst = 1'b1;
      #1;
      checkOutput("async reset state", {if15.out_valid, if15.fifo_cnt, d15.crd_out, if15.rxlcrdv}, 0);
      step();
      checkOutput("reset next cycle", {if15.out_valid, if15.fifo_cnt, d15.crd_out, if15.rxlcrdv}, 0);

      // Streaming on DEPTH=4: transmitter spends each credit as it arrives
      $display("[TB] streaming on DEPTH=4");
      applyReset(1'b1);
      if4.out_ready = 1'b1;
      tx_cred  = 0;
      sent     = 0;
      received = 0;
      cycles   = 0;
      while (received < 40 && cycles < 200) begin
         if (if4.out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL stream extra flit: got 0x%0h, expected none", if4.out_flit);
            end else begin
               checkOutput($sformatf("stream flit %0d", received), if4.out_flit, exp_q.pop_front());
            end
            received++;
         end
         tx_cred += int'(if4.rxlcrdv);
         if (tx_cred > 0 && sent < 40) begin
            if4.rxflitv = 1'b1;
            if4.rxflit  = 16'h9000 | 16'(sent);
            exp_q.push_back(16'h9000 | 16'(sent));
            sent++;
            tx_cred--;
         end else begin
            if4.rxflitv = 1'b0;
         end
         step();
         cycles++;
      end
      if4.rxflitv = 1'b0;
      checkOutput("stream received count", received, 40);
      checkOutput("stream within cycle budget", cycles <= 60, 1);
      checkOutput("stream error flags", {if4.err_nocrd, if4.err_ovf}, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
